// File: rtl/uart_word_buffer_if.sv
// Byte-in / word-out bus for the UART word buffer.
// The master side feeds received bytes and pops words; the buffer is the slave.
interface uart_word_buffer_if #(
  parameter int DEPTH = 16
);
  logic [7:0]              byte_data;
  logic                    byte_ok;
  logic                    rd_en;
  logic                    clr_overflow;
  logic [31:0]             word;
  logic                    valid;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic [1:0]              partial;

  modport master (
    output byte_data, byte_ok, rd_en, clr_overflow,
    input  word, valid, count, overflow, partial
  );
  modport slave (
    input  byte_data, byte_ok, rd_en, clr_overflow,
    output word, valid, count, overflow, partial
  );
endinterface

// File: rtl/uart_word_buffer.sv
// Packs UART bytes little-endian into 32-bit words and queues them in a
// first-word-fall-through FIFO. A stalled partial word is dropped after TIMEOUT idle cycles.
module uart_word_buffer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  uart_word_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int TL = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [IW-1:0] TLAST = TL[IW-1:0];

  logic [23:0]   asm_q;
  logic [1:0]    partial_q;
  logic [IW-1:0] idle_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          ovf_q;

  logic full, push, pop, accept, ovf_evt, tmo;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop     = bus.rd_en && (count_q != '0);
  assign push    = bus.byte_ok && (partial_q == 2'd3);
  assign accept  = push && (!full || pop);
  assign ovf_evt = push && full && !pop;
  // Discard fires on the edge where the idle count would reach TIMEOUT.
  assign tmo     = (TIMEOUT != 0) && !bus.byte_ok && (partial_q != 2'd0) && (idle_q == TLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      partial_q <= 2'd0;
      idle_q    <= '0;
    end else if (bus.byte_ok) begin
      partial_q <= partial_q + 2'd1;
      idle_q    <= '0;
    end else if (partial_q == 2'd0 || tmo) begin
      partial_q <= 2'd0;
      idle_q    <= '0;
    end else begin
      idle_q    <= idle_q + 1'b1;
    end
  end

  // Data path carries no reset; partial_q qualifies what is meaningful.
  always_ff @(posedge clk) begin
    if (!reset && bus.byte_ok) begin
      case (partial_q)
        2'd0:    asm_q[7:0]   <= bus.byte_data;
        2'd1:    asm_q[15:8]  <= bus.byte_data;
        2'd2:    asm_q[23:16] <= bus.byte_data;
        default: ;
      endcase
    end
    if (!reset && accept) mem[wr_ptr] <= {bus.byte_data, asm_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (ovf_evt)               ovf_q <= 1'b1;
      else if (bus.clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign bus.word     = mem[rd_ptr];
  assign bus.valid    = (count_q != '0);
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.partial  = partial_q;
endmodule

// File: tb/tb_uart_word_buffer.sv
// Scoreboard bench for uart_word_buffer with a small FIFO and short timeout.
module tb_uart_word_buffer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  uart_word_buffer_if #(.DEPTH(DEPTH)) bus ();
  uart_word_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_data = b; bus.byte_ok = 1'b1;
    tick();
    bus.byte_ok = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_store);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    if (expect_store) exp_q.push_back(w);
  endtask

  task automatic pop_one(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_word"}, bus.word, e);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_data = 8'h00; bus.byte_ok = 1'b0; bus.rd_en = 1'b0; bus.clr_overflow = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_partial", 32'(bus.partial), 32'd0);

    // byte order
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    chk("bo_partial3", 32'(bus.partial), 32'd3);
    chk("bo_valid_early", {31'd0, bus.valid}, 32'd0);
    send_byte(8'h12); exp_q.push_back(32'h12345678);
    chk("bo_count", 32'(bus.count), 32'd1);
    chk("bo_partial0", 32'(bus.partial), 32'd0);
    pop_one("bo");
    chk("bo_count_after", 32'(bus.count), 32'd0);

    // pop on empty
    bus.rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty_count", 32'(bus.count), 32'd0);
      chk("empty_valid", {31'd0, bus.valid}, 32'd0);
    end
    bus.rd_en = 1'b0;
    send_word(32'hCAFEF00D, 1'b1);
    pop_one("empty_after");

    // fill and overflow
    for (int i = 1; i <= 5; i++) begin
      send_word(32'h1000_0000 + 32'(i), i <= DEPTH);
      if (i == DEPTH) chk("fill_ovf_pre", {31'd0, bus.overflow}, 32'd0);
    end
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_ovf", {31'd0, bus.overflow}, 32'd1);
    chk("fill_partial", 32'(bus.partial), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_one("fill_pop");
    chk("fill_drained", 32'(bus.count), 32'd0);
    chk("fill_ovf_held", {31'd0, bus.overflow}, 32'd1);
    bus.clr_overflow = 1'b1; tick(); bus.clr_overflow = 1'b0;
    chk("fill_ovf_clr", {31'd0, bus.overflow}, 32'd0);

    // push and pop on full
    for (int i = 0; i < DEPTH; i++) send_word(32'hA000_0000 + 32'(i), 1'b1);
    send_byte(8'hE0); send_byte(8'hE1); send_byte(8'hE2);
    chk("pp_head", bus.word, exp_q.pop_front());
    bus.rd_en = 1'b1; send_byte(8'hE3); bus.rd_en = 1'b0;
    exp_q.push_back(32'hE3E2E1E0);
    chk("pp_count", 32'(bus.count), 32'd4);
    chk("pp_ovf", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_one("pp_pop");
    chk("pp_drained", 32'(bus.count), 32'd0);

    // clear and new overflow on the same edge: set wins
    for (int i = 0; i < DEPTH; i++) send_word(32'hB000_0000 + 32'(i), 1'b1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    bus.clr_overflow = 1'b1; send_byte(8'h04); bus.clr_overflow = 1'b0;
    chk("setwin_ovf", {31'd0, bus.overflow}, 32'd1);
    chk("setwin_count", 32'(bus.count), 32'd4);
    bus.clr_overflow = 1'b1; tick(); bus.clr_overflow = 1'b0;
    chk("setwin_clr", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_one("setwin_pop");

    // timeout
    send_byte(8'h11); send_byte(8'h22);
    chk("tmo_partial2", 32'(bus.partial), 32'd2);
    idle(TIMEOUT);
    chk("tmo_partial0", 32'(bus.partial), 32'd0);
    chk("tmo_count", 32'(bus.count), 32'd0);
    chk("tmo_ovf", {31'd0, bus.overflow}, 32'd0);
    send_word(32'hDDCCBBAA, 1'b1);
    pop_one("tmo_word");

    // byte just before timeout keeps the partial word alive
    send_byte(8'h55);
    idle(TIMEOUT - 1);
    send_byte(8'h66);
    chk("tmo_prio_partial", 32'(bus.partial), 32'd2);
    idle(TIMEOUT);
    chk("tmo_prio_expire", 32'(bus.partial), 32'd0);

    // reset mid-operation, with inputs active during reset
    for (int i = 0; i < 3; i++) send_word(32'hC000_0000 + 32'(i), 1'b1);
    send_byte(8'h9A); send_byte(8'h9B);
    chk("mid_count", 32'(bus.count), 32'd3);
    chk("mid_partial", 32'(bus.partial), 32'd2);
    reset = 1'b1; bus.byte_ok = 1'b1; bus.rd_en = 1'b1; bus.byte_data = 8'hFF;
    tick();
    reset = 1'b0; bus.byte_ok = 1'b0; bus.rd_en = 1'b0;
    exp_q.delete();
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("mid_rst_partial", 32'(bus.partial), 32'd0);
    send_word(32'h0BADBEEF, 1'b1);
    chk("mid_after_count", 32'(bus.count), 32'd1);
    pop_one("mid_after");
    chk("mid_final_count", 32'(bus.count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_word_buffer.md
UART_WORD_BUFFER -- requirements
Module: uart_word_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: word FIFO depth; power of two, >= 2.
REQ-002 SHALL have parameter TIMEOUT, default 1000000: idle clock cycles before a partial word is discarded; 0 disables the timeout.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port byte_data, input, 8 bits: received byte from the UART receiver.
REQ-006 SHALL have port byte_ok, input, 1 bit: one-cycle strobe; byte_data is valid in that cycle.
REQ-007 SHALL have port rd_en, input, 1 bit: consumer pop request.
REQ-008 SHALL have port clr_overflow, input, 1 bit: clears the sticky overflow flag.
REQ-009 SHALL have port word, output, 32 bits: FIFO head word.
REQ-010 SHALL have port valid, output, 1 bit: FIFO non-empty, so word is meaningful.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored words, range 0..DEPTH.
REQ-012 SHALL have port overflow, output, 1 bit: sticky; a completed word was dropped.
REQ-013 SHALL have port partial, output, 2 bits: bytes held in the assembler, range 0..3.

Function
REQ-014 SHALL capture byte_data into the assembler in every cycle where byte_ok=1, with no other qualification.
REQ-015 SHALL assemble bytes little-endian: the 1st byte goes to bits 7:0, the 2nd to 15:8, the 3rd to 23:16 and the 4th to 31:24.
REQ-016 SHALL increment partial modulo 4 on each captured byte.
REQ-017 SHALL, on the edge that captures the 4th byte, write the completed word into the FIFO and return partial to 0.
REQ-018 SHALL make a written word visible at word/valid on the cycle after the write edge.
REQ-019 SHALL, if the FIFO is full at the write edge and no pop occurs at that edge, drop the completed word, set overflow, and still return partial to 0.
REQ-020 SHALL, if the FIFO is full and a push and a pop occur at the same edge, accept the push with count unchanged and set no overflow.
REQ-021 SHALL operate as first-word-fall-through: word presents the head entry whenever valid=1.
REQ-022 SHALL pop the head entry when rd_en=1 and valid=1.
REQ-023 SHALL ignore rd_en when valid=0: no state change, count stays 0.
REQ-024 SHALL, on a simultaneous push and pop while not full, leave count unchanged and keep FIFO order.
REQ-025 SHALL treat the word value as don't-care while valid=0.
REQ-026 SHALL assert valid if and only if count != 0.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH.
REQ-028 SHALL keep count exact across pointer wrap-around, with no full/empty ambiguity.
REQ-029 SHALL run an idle counter while partial != 0, cleared on every byte_ok.
REQ-030 SHALL, when the idle counter reaches TIMEOUT with no byte_ok in that cycle, discard the partial bytes, set partial to 0, and leave the FIFO and overflow unaffected.
REQ-031 SHALL give byte_ok priority over the timeout when both occur in the same cycle: the byte is captured and the counter is cleared.
REQ-032 SHALL hold the idle counter at 0 while partial=0.
REQ-033 SHALL never trigger the timeout when TIMEOUT=0.
REQ-034 SHALL clear overflow on clr_overflow=1.
REQ-035 SHALL, when a clear and a new overflow event occur at the same edge, leave overflow set (set wins).
REQ-036 SHALL have no combinational path from byte_ok or byte_data to any output.
REQ-037 SHALL drive word, valid, count and overflow from registers or FIFO storage only.

Reset
REQ-038 SHALL, while reset=1 at an edge, set count=0, valid=0, overflow=0, partial=0, the idle counter to 0 and both pointers to 0.
REQ-039 SHALL ignore byte_ok, rd_en and clr_overflow in reset cycles.
REQ-040 SHALL, on reset mid-word or with the FIFO non-empty, discard all buffered bytes and words with no output side effects afterwards.
REQ-041 SHALL not reset the FIFO storage array; its contents are unobservable while valid=0.

Verification
REQ-042 SHALL cover byte order: bytes 0x78, 0x56, 0x34, 0x12 -> the cycle after the 4th strobe valid=1, word=0x12345678, count=1, partial=0.
REQ-043 SHALL cover fill and overflow with DEPTH=4: 5 words sent with rd_en=0 -> count=4 and overflow=1 after the 5th; popping 4 times returns words 1..4 in order; clr_overflow then gives overflow=0.
REQ-044 SHALL cover push and pop on a full FIFO: 4th byte of a new word and rd_en=1 at the same edge -> count stays 4, overflow=0, the new word is read last.
REQ-045 SHALL cover the timeout with TIMEOUT=10: send 2 bytes then idle 10 cycles -> partial=0; the next 4 bytes 0xAA, 0xBB, 0xCC, 0xDD -> word=0xDDCCBBAA.
REQ-046 SHALL cover reset mid-operation: 3 words stored and partial=2, then reset for 1 cycle -> count=0, valid=0, partial=0; the next full word reads back alone.
REQ-047 SHALL cover pop on empty: rd_en=1 with count=0 for 5 cycles -> count stays 0, valid=0, no pointer corruption; a subsequent word reads back correctly.
